// File: rtl/btn_pulse_pkg.sv
// btn_pkg: shared types and default constants for the push-button conditioning stage.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } btn_state_t;

  // 10 ms debounce window at 100 MHz
  localparam logic [31:0] DEB_CNT_DEF = 32'd1_000_000;
  // 0.5 s until the first auto-repeat, then one repeat every 0.2 s
  localparam logic [31:0] REP_DLY_DEF = 32'd50_000_000;
  localparam logic [31:0] REP_PER_DEF = 32'd20_000_000;

endpackage

// File: rtl/btn_pulse_if.sv
// Button bus: raw input towards the conditioner, pulse and level back out.
interface btn_pulse_if;

  logic BTN_IN;
  logic BTN_PULSE;
  logic BTN_LEVEL;

  // board / stimulus side
  modport master (output BTN_IN, input BTN_PULSE, input BTN_LEVEL);
  // conditioner side
  modport slave  (input BTN_IN, output BTN_PULSE, output BTN_LEVEL);

endinterface

// File: rtl/btn_pulse_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  // two-stage metastability filter, both stages cleared by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_pulse.sv
// btn_pulse: synchronise, debounce and edge-detect a raw push-button.
// Emits one registered BTN_PULSE per confirmed press plus a debounced BTN_LEVEL.
// Optional auto-repeat while held: define BTN_REPEAT_EN.
module btn_pulse
  import btn_pkg::*;
#(
  parameter logic [31:0] DEB_CNT = DEB_CNT_DEF
`ifdef BTN_REPEAT_EN
  ,
  parameter logic [31:0] REP_DLY = REP_DLY_DEF,
  parameter logic [31:0] REP_PER = REP_PER_DEF
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  btn_pulse_if.slave btn
);

  logic        s;
  btn_state_t  state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        level, level_nxt;
  logic        pulse, pulse_nxt;
`ifdef BTN_REPEAT_EN
  logic [31:0] rcnt, rcnt_nxt;
`endif

  sync_2ff #(.WIDTH(1)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (btn.BTN_IN),
    .q   (s)
  );

  // state, stability counter and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      level <= level_nxt;
      pulse <= pulse_nxt;
    end
  end

`ifdef BTN_REPEAT_EN
  // hold-time counter for auto-repeat
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rcnt <= '0;
    else     rcnt <= rcnt_nxt;
  end
`endif

  // debounce FSM: next state, counter and pulse/level decisions
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level;
    pulse_nxt = 1'b0;
    case (state)
      RELEASED: begin
        if (s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s) begin
          state_nxt = RELEASED;
        end else if (cnt == DEB_CNT - 32'd1) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_nxt = PRESSED;
        end else if (cnt == DEB_CNT - 32'd1) begin
          state_nxt = RELEASED;
          level_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
        pulse_nxt = 1'b0;
      end
    endcase
`ifdef BTN_REPEAT_EN
    // Reloading with REP_DLY-REP_PER (mod 2^32) makes the next match with
    // REP_DLY-1 land exactly REP_PER cycles later, so one compare serves both
    // the initial delay and the repeat period.
    rcnt_nxt = '0;
    if (state == PRESSED) begin
      if (rcnt == REP_DLY - 32'd1) begin
        pulse_nxt = 1'b1;
        rcnt_nxt  = REP_DLY - REP_PER;
      end else begin
        rcnt_nxt = rcnt + 32'd1;
      end
    end
`endif
  end

  assign btn.BTN_PULSE = pulse;
  assign btn.BTN_LEVEL = level;

endmodule

// File: doc/btn_pulse.md
# btn_pulse

Button conditioning stage placed directly in front of the start/stop counter. It synchronises a raw, bouncing push-button input into the `CLK` domain, debounces it with a stability counter, and emits a single-cycle `BTN_PULSE` on each confirmed press. The counter consumes that pulse as its `BTN` input, so one physical press toggles start/stop exactly once. A debounced level output and an optional auto-repeat feature are also provided.

## Interface
- `DEB_CNT`, 1_000_000: consecutive stable cycles required to accept a press or release (10 ms at 100 MHz); legal range 1..2^32-1.
- `REP_DLY`, 50_000_000: cycles from the initial press pulse to the first repeat pulse; used only with `BTN_REPEAT_EN`.
- `REP_PER`, 20_000_000: cycles between subsequent repeat pulses; used only with `BTN_REPEAT_EN`.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `BTN_IN`  in  1  raw asynchronous button input, active-high.
- `BTN_PULSE`  out  1  one-cycle pulse per accepted press (and per repeat when enabled).
- `BTN_LEVEL`  out  1  debounced button level.

## Operation
- Two-flop synchroniser: `BTN_IN` → `s1` → `s`; both reset to 0.
- 32-bit stability counter `CNT`; FSM states:
  - RELEASED: `s`=1 → PRESS_CHK, `CNT`<=0.
  - PRESS_CHK: `s`=0 → RELEASED. Otherwise `CNT`<=`CNT`+1. When `CNT`==`DEB_CNT`-1 → PRESSED, `BTN_LEVEL`<=1, `BTN_PULSE`<=1.
  - PRESSED: `s`=0 → RELEASE_CHK, `CNT`<=0.
  - RELEASE_CHK: `s`=1 → PRESSED, with no pulse and no change to `BTN_LEVEL`. Otherwise count. When `CNT`==`DEB_CNT`-1 → RELEASED, `BTN_LEVEL`<=0.
- `BTN_PULSE` is registered. It defaults to 0 every cycle and is set only on the transition edges listed above (plus repeat edges).
- Release never produces a pulse.
- Unreachable state encodings → RELEASED, with `BTN_LEVEL`=0 and `BTN_PULSE`=0.
- Comparisons are exact equality on the 32-bit `CNT`; `CNT` never exceeds `DEB_CNT`-1, so no wrap occurs.

## Timing
- Reset values: `BTN_PULSE`=0, `BTN_LEVEL`=0, state RELEASED, `CNT`=0, synchroniser flops 0. These take effect immediately on `RST` assertion, including mid-count. Any pending press is discarded.
- Press latency: `BTN_IN` is high and stable from rising edge 1 onward. `BTN_PULSE` and `BTN_LEVEL` rise after edge `DEB_CNT`+3. `BTN_PULSE` is high for exactly one cycle.
- Release latency: `BTN_LEVEL` falls `DEB_CNT`+3 edges after the first edge sampling `BTN_IN` low.
- Any glitch shorter than `DEB_CNT` synchronised cycles is rejected, and the counter restarts from 0 on the next qualifying edge.
- Minimum spacing between non-repeat pulses is 2·(`DEB_CNT`+1) cycles.

## Configuration
- Macro: `BTN_REPEAT_EN`.
- **Defined:** adds a 32-bit repeat counter `RCNT`, cleared on every cycle the FSM is not in PRESSED.
  - In PRESSED, `RCNT` increments every cycle.
  - When `RCNT`==`REP_DLY`-1, a pulse is emitted and `RCNT` is reloaded so the next pulse occurs `REP_PER` cycles later; this repeats while held.
  - A bounce through RELEASE_CHK restarts the `REP_DLY` delay.
- **Undefined:** no repeat logic; exactly one pulse per press. `REP_DLY` and `REP_PER` are ignored.

## Structure
- Package `btn_pkg`:
  - FSM state type (RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK, 2-bit encoding).
  - Default constants for `DEB_CNT`, `REP_DLY`, `REP_PER`.
- Sub-module `sync_2ff`: a generic two-flop synchroniser with async active-high reset, reusable for other board inputs.

## Test plan
Bench parameters: `DEB_CNT`=4, `REP_DLY`=10, `REP_PER`=3.
- **Clean press:** `BTN_IN` 0→1 and held 20 cycles → `BTN_PULSE` high for exactly 1 cycle after edge 7, `BTN_LEVEL`=1 from edge 7.
- **Bounce rejection:** `BTN_IN` toggles 1,0,1,0 on single cycles, then stays 0 → `BTN_PULSE` never asserts and `BTN_LEVEL` stays 0.
- **Release bounce:** while pressed, drop `BTN_IN` for 2 cycles then restore → `BTN_LEVEL` stays 1, no pulse. Hold low ≥7 cycles → `BTN_LEVEL`=0, no pulse.
- **Reset mid-count:** assert `RST` asynchronously during PRESS_CHK (e.g. `CNT`=2) → outputs 0 immediately. After release of reset with `BTN_IN` held, the full 7-edge latency applies again.
- **Back-to-back presses:** 3 presses, each 6 cycles high and 6 low → exactly 3 pulses on `BTN_PULSE`; toggling a downstream counter's state 3 times ends in the running state.
- **Repeat (`BTN_REPEAT_EN` defined):** hold 30 cycles → pulses at edge 7, then 10, 13, 16… cycles after that. Without the macro, a single pulse at edge 7.
